// File: rtl/irq_dispatch.sv
// irq_dispatch: turns level-style request flags from the interrupt priority
// controller into one FIFO entry per distinct {bus,channel} event, so a
// request held for many cycles is reported once.
module irq_dispatch #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pa,
  input  logic                     pb,
  input  logic                     pc,
  input  logic [3:0]               chan,
  input  logic                     out_ready,
  input  logic                     ovf_clr,
  output logic                     out_valid,
  output logic [1:0]               out_bus,
  output logic [3:0]               out_chan,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, HELD} state_t;

  logic         pa_q, pb_q, pc_q;
  logic [3:0]   chan_q;
  logic [1:0]   bus_q;
  logic [5:0]   cur;

  state_t       state, next_state;
  logic [5:0]   key, next_key;
  logic         push;

  logic [5:0]   mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic         full, pop, wr, drop;

  // Input stage: one register layer between the controller and the event logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pa_q   <= 1'b0;
      pb_q   <= 1'b0;
      pc_q   <= 1'b0;
      chan_q <= 4'd0;
    end else begin
      pa_q   <= pa;
      pb_q   <= pb;
      pc_q   <= pc;
      chan_q <= chan;
    end
  end

  // Fixed-priority bus code from the registered flags; 0 means no request.
  always_comb begin
    bus_q = 2'd0;
    if (pa_q)      bus_q = 2'd1;
    else if (pb_q) bus_q = 2'd2;
    else if (pc_q) bus_q = 2'd3;
  end

  assign cur = {bus_q, chan_q};

  // Event detector state and the key of the request currently being held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      key   <= 6'd0;
    end else begin
      state <= next_state;
      key   <= next_key;
    end
  end

  // Push on a new request, or on a change of request while one is held.
  always_comb begin
    next_state = state;
    next_key   = key;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (bus_q != 2'd0) begin
          push       = 1'b1;
          next_key   = cur;
          next_state = HELD;
        end
      end
      HELD: begin
        if (bus_q == 2'd0) begin
          next_state = IDLE;
        end else if (cur != key) begin
          push     = 1'b1;
          next_key = cur;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign out_valid = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign pop       = out_valid & out_ready;
  assign wr        = push & (~full | pop);
  assign drop      = push & full & ~pop;

  // Storage array; a write into a full FIFO lands in the slot being popped.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= cur;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (wr)  wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      case ({wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  assign out_bus  = out_valid ? mem[rptr][5:4] : 2'd0;
  assign out_chan = out_valid ? mem[rptr][3:0] : 4'd0;

endmodule

// File: tb/tb_irq_dispatch.sv
// tb_irq_dispatch: directed scenarios with literal expectations followed by
// randomized traffic, all compared every cycle against an event-level model.
module tb_irq_dispatch;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pa = 1'b0, pb = 1'b0, pc = 1'b0;
  logic [3:0] chan = 4'd0;
  logic       out_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       out_valid;
  logic [1:0] out_bus;
  logic [3:0] out_chan;
  logic [$clog2(DEPTH):0] count;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  irq_dispatch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pa(pa), .pb(pb), .pc(pc), .chan(chan),
    .out_ready(out_ready), .ovf_clr(ovf_clr), .out_valid(out_valid),
    .out_bus(out_bus), .out_chan(out_chan), .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Request code seen by the consumer; chan is meaningless without a bus flag.
  function automatic logic [5:0] encode(input logic a, input logic b, input logic c,
                                        input logic [3:0] ch);
    if (a) return {2'd1, ch};
    if (b) return {2'd2, ch};
    if (c) return {2'd3, ch};
    return 6'd0;
  endfunction

  // Event-level model: an event is a registered non-idle request that differs
  // from the previous cycle's registered request.
  logic [5:0] mq[$];
  logic [5:0] m_cur, m_prev;
  logic       m_ovf;
  logic       m_push, m_pop, m_drop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_cur  = 6'd0;
      m_prev = 6'd0;
      m_ovf  = 1'b0;
    end else begin
      m_push = (m_cur[5:4] != 2'd0) && (m_cur != m_prev);
      m_pop  = (mq.size() != 0) && out_ready;
      m_drop = 1'b0;
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (mq.size() < DEPTH) mq.push_back(m_cur);
        else m_drop = 1'b1;
      end
      if (m_drop)       m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_prev = m_cur;
      m_cur  = encode(pa, pb, pc, chan);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkHead(input string tag, input logic [5:0] e);
    checkOutput({tag, "_valid"}, int'(out_valid), 1);
    checkOutput({tag, "_bus"}, int'(out_bus), int'(e[5:4]));
    checkOutput({tag, "_chan"}, int'(out_chan), int'(e[3:0]));
  endtask

  // Drive one input pattern from a falling edge and hold it for n rising edges.
  task automatic applyStimulus(input logic a, input logic b, input logic c,
                               input logic [3:0] ch, input logic rdy, input int n);
    pa = a; pb = b; pc = c; chan = ch; out_ready = rdy;
    repeat (n) @(negedge clk);
  endtask

  // Per-cycle comparison against the model, well clear of both clock edges.
  always @(posedge clk) begin
    #3;
    if (check_en) begin
      checkOutput("m_valid", int'(out_valid), int'(mq.size() != 0));
      checkOutput("m_bus",   int'(out_bus),   mq.size() != 0 ? int'(mq[0][5:4]) : 0);
      checkOutput("m_chan",  int'(out_chan),  mq.size() != 0 ? int'(mq[0][3:0]) : 0);
      checkOutput("m_count", int'(count),     mq.size());
      checkOutput("m_ovf",   int'(ovf),       int'(m_ovf));
    end
  end

  logic [5:0] exp035 [3] = '{6'h15, 6'h29, 6'h15};
  logic [5:0] exp037 [4] = '{6'h12, 6'h13, 6'h24, 6'h37};
  int pulses;
  int hold;

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_valid", int'(out_valid), 0);
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_ovf", int'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Held request reported once, two edges after it is driven
    applyStimulus(1, 0, 0, 5, 0, 1);
    checkOutput("lat_n", int'(out_valid), 0);
    applyStimulus(1, 0, 0, 5, 0, 1);
    checkHead("lat_n1", 6'h15);
    applyStimulus(1, 0, 0, 5, 0, 8);
    checkOutput("held_count", int'(count), 1);
    checkHead("held", 6'h15);
    applyStimulus(0, 0, 0, 0, 1, 3);
    checkOutput("drain0_count", int'(count), 0);
    checkOutput("empty_bus", int'(out_bus), 0);

    // Change of bus, idle gap and a repeat of the first request
    applyStimulus(1, 0, 0, 5, 0, 2);
    applyStimulus(0, 1, 0, 9, 0, 2);
    applyStimulus(0, 0, 0, 0, 0, 2);
    applyStimulus(1, 0, 0, 5, 0, 2);
    applyStimulus(0, 0, 0, 0, 0, 3);
    checkOutput("seq_count", int'(count), 3);
    for (int i = 0; i < 3; i++) begin
      checkHead($sformatf("seq%0d", i), exp035[i]);
      applyStimulus(0, 0, 0, 0, 1, 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("seq_empty", int'(count), 0);

    // Five back-to-back events into a four-entry FIFO
    applyStimulus(1, 0, 0, 1, 0, 1);
    applyStimulus(1, 0, 0, 2, 0, 1);
    applyStimulus(1, 0, 0, 3, 0, 1);
    applyStimulus(0, 1, 0, 4, 0, 1);
    applyStimulus(0, 0, 1, 5, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 3);
    checkOutput("full_count", int'(count), 4);
    checkOutput("full_ovf", int'(ovf), 1);
    checkHead("full_head", 6'h11);
    ovf_clr = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 1);
    ovf_clr = 1'b0;
    checkOutput("ovf_clr", int'(ovf), 0);

    // Push and pop on the same edge while full
    applyStimulus(0, 0, 1, 7, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("pp_count", int'(count), 4);
    checkOutput("pp_ovf", int'(ovf), 0);
    for (int i = 0; i < 4; i++) begin
      checkHead($sformatf("pp%0d", i), exp037[i]);
      applyStimulus(0, 0, 0, 0, 1, 1);
    end
    checkOutput("pp_empty", int'(count), 0);

    // Reset while three entries are queued and a request is held
    applyStimulus(1, 0, 0, 1, 0, 1);
    applyStimulus(1, 0, 0, 2, 0, 1);
    applyStimulus(1, 0, 0, 3, 0, 3);
    checkOutput("pre_rst_count", int'(count), 3);
    rst = 1'b1;
    #1;
    checkOutput("rst_now_valid", int'(out_valid), 0);
    checkOutput("rst_now_count", int'(count), 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 0, 0, 3, 0, 1);
    checkOutput("post_rst_lat", int'(count), 0);
    applyStimulus(1, 0, 0, 3, 0, 1);
    checkOutput("post_rst_count", int'(count), 1);
    checkHead("post_rst", 6'h13);
    applyStimulus(0, 0, 0, 0, 1, 3);

    // Consumer always ready, events three cycles apart
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 0, 4'(i), 1, 1);
      if (out_valid) pulses++;
      applyStimulus(0, 0, 0, 0, 1, 1);
      if (out_valid) pulses++;
      applyStimulus(0, 0, 0, 0, 1, 1);
      if (out_valid) pulses++;
    end
    checkOutput("rdy_pulses", pulses, 6);
    checkOutput("rdy_ovf", int'(ovf), 0);
    checkOutput("rdy_count", int'(count), 0);

    // Randomized traffic with small channel range so repeats are common
    for (int i = 0; i < 1500; i++) begin
      hold = $urandom_range(1, 3);
      ovf_clr = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 1) == 0, 4'($urandom_range(0, 3)),
                    $urandom_range(0, 2) == 0, hold);
    end
    ovf_clr = 1'b0;
    applyStimulus(0, 0, 0, 0, 1, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_dispatch.md
IRQ_DISPATCH -- requirements
Module: irq_dispatch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the event FIFO depth in entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port pa, input, 1 bit, bus-A request flag from the interrupt priority controller.
REQ-005 The block SHALL have port pb, input, 1 bit, bus-B request flag from the same controller.
REQ-006 The block SHALL have port pc, input, 1 bit, bus-C request flag from the same controller.
REQ-007 The block SHALL have port chan, input, 4 bits, encoded winning-channel code from the same controller.
REQ-008 The block SHALL have port out_ready, input, 1 bit, consumer ready.
REQ-009 The block SHALL have port ovf_clr, input, 1 bit, synchronous clear of the overflow flag.
REQ-010 The block SHALL have port out_valid, output, 1 bit, high when the FIFO holds an entry.
REQ-011 The block SHALL have port out_bus, output, 2 bits, head-entry bus code: 1=A, 2=B, 3=C.
REQ-012 The block SHALL have port out_chan, output, 4 bits, head-entry channel code.
REQ-013 The block SHALL have port count, output, clog2(DEPTH)+1 bits, number of occupied entries.
REQ-014 The block SHALL have port ovf, output, 1 bit, sticky overflow flag.

Function
REQ-015 The block SHALL register pa, pb, pc and chan in one input stage (in_q) every cycle.
REQ-016 The block SHALL form bus_q = 1 if pa_q, else 2 if pb_q, else 3 if pc_q, else 0.
REQ-017 The block SHALL run a two-state FSM: IDLE and HELD, with a 6-bit key register {bus,chan}.
REQ-018 In IDLE with bus_q!=0, the block SHALL push {bus_q,chan_q}, load key, and go to HELD.
REQ-019 In HELD with bus_q==0, the block SHALL go to IDLE with no push.
REQ-020 In HELD with bus_q!=0 and {bus_q,chan_q}!=key, the block SHALL push, update key, and stay in HELD.
REQ-021 In HELD with {bus_q,chan_q}==key, the block SHALL neither push nor change state.
REQ-022 chan_q SHALL be ignored while bus_q==0.
REQ-023 Latency SHALL be 2 cycles: an input changing before edge N is registered at N and pushed at N+1, and out_valid SHALL be visible after N+1 when the FIFO was empty.
REQ-024 A pop SHALL occur on any edge where out_valid and out_ready are both 1, and the FIFO SHALL be first-in first-out.
REQ-025 out_bus and out_chan SHALL show the head entry when out_valid=1 and SHALL be 0 when the FIFO is empty.
REQ-026 A push into a full FIFO with no pop in the same cycle SHALL be dropped and SHALL set ovf; FSM and key SHALL still update.
REQ-027 A simultaneous push and pop when full SHALL accept the push, and count SHALL remain DEPTH.
REQ-028 A simultaneous push and pop when empty SHALL not pop, and count SHALL become 1.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH, and count SHALL never exceed DEPTH.
REQ-030 ovf_clr SHALL clear ovf on the next edge; if an overflow drop happens in that same cycle, ovf SHALL remain set.

Reset
REQ-031 rst SHALL immediately clear in_q, key, pointers, count and ovf, set out_valid=0, out_bus=0, out_chan=0, and set the FSM to IDLE.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries.
REQ-033 After reset deassertion, the first push SHALL require bus_q!=0 to be registered after the release edge.

Verification
REQ-034 Drive pa=1, chan=5 for 10 cycles with out_ready=0 -> exactly one entry (out_bus=1, out_chan=5) appears 2 cycles later, and count=1.
REQ-035 Drive pa=1/chan=5, then pb=1 (pa=0)/chan=9, then all idle, then pa=1/chan=5 -> three entries in order: (1,5), (2,9), (1,5).
REQ-036 With DEPTH=4 and out_ready=0, generate 5 distinct events -> count=4, ovf=1, the first four entries are kept, and ovf_clr clears ovf.
REQ-037 With the FIFO full, push and pop in the same cycle -> count stays 4, the oldest entry leaves and the new entry is at the tail.
REQ-038 Assert rst while count=3 and the FSM is HELD -> out_valid=0 and count=0 at once, and an identical held input after release is pushed again.
REQ-039 Hold out_ready=1 while 6 events arrive spaced 3 cycles apart -> each entry is popped, out_valid pulses once per event, and ovf stays 0.
